// File: rtl/basemul_acc.sv
// Multi-lane Kyber base-case multiplier with in-stream accumulation.
// Operands are registered on entry, then multiply / fold / reduce / accumulate stages.
module basemul_acc #(
  parameter int LANES = 2,
  parameter int Q     = 3329,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               set,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [LANES*W-1:0] a1,
  input  logic [LANES*W-1:0] a0,
  input  logic [LANES*W-1:0] b1,
  input  logic [LANES*W-1:0] b0,
  input  logic [LANES*W-1:0] zeta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] t1,
  output logic [LANES*W-1:0] t0,
  output logic               acc_err
);

  localparam int QW = $clog2(Q);
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;
  localparam logic signed [SW-1:0] QS = SW'(Q);
  localparam logic [QW:0]          QE = (QW+1)'(Q);

  // Exact signed reduction to the canonical range [0, Q).
  function automatic logic [QW-1:0] mod_q(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = x % QS;
    if (r < 0) r = r + QS;
    return r[QW-1:0];
  endfunction

  // Handshake: a beat transfers when in_valid && in_ready, a result when
  // out_valid && out_ready; the whole pipeline moves only when the output
  // register is free or being drained this cycle.
  logic w_adv;
  assign w_adv    = out_ready || !out_valid;
  assign in_ready = w_adv;

  logic r0_v, r0_f, r0_l;
  logic r1_v, r1_f, r1_l;
  logic r2_v, r2_f, r2_l;
  logic r3_v, r3_f, r3_l;
  logic r_open, r_ov, r_err;
  logic w_fresh;

  assign w_fresh   = r3_f || !r_open;
  assign out_valid = r_ov;
  assign acc_err   = r_err;

  always_ff @(posedge clk) begin
    if (!set) begin
      r0_v   <= 1'b0;
      r1_v   <= 1'b0;
      r2_v   <= 1'b0;
      r3_v   <= 1'b0;
      r0_f   <= 1'b0;
      r0_l   <= 1'b0;
      r1_f   <= 1'b0;
      r1_l   <= 1'b0;
      r2_f   <= 1'b0;
      r2_l   <= 1'b0;
      r3_f   <= 1'b0;
      r3_l   <= 1'b0;
      r_open <= 1'b0;
      r_ov   <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_adv) begin
      r0_v <= in_valid;
      r0_f <= in_first;
      r0_l <= in_last;
      r1_v <= r0_v;
      r1_f <= r0_f;
      r1_l <= r0_l;
      r2_v <= r1_v;
      r2_f <= r1_f;
      r2_l <= r1_l;
      r3_v <= r2_v;
      r3_f <= r2_f;
      r3_l <= r2_l;
      if (r3_v) begin
        // first inside an open burst, or a continuation with none open
        if (r3_f == r_open) r_err <= 1'b1;
        r_open <= !r3_l;
      end
      r_ov <= r3_v && r3_l;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [W-1:0]  r0_a1, r0_a0, r0_b1, r0_b0, r0_z;
    logic signed [PW-1:0] r1_p00, r1_p11, r1_p01, r1_p10;
    logic signed [W-1:0]  r1_z;
    logic signed [SW-1:0] r2_s0, r2_s1;
    logic [QW-1:0]        r3_t0, r3_t1;
    logic [QW-1:0]        r_acc0, r_acc1, r_t0, r_t1;
    logic [QW-1:0]        w_r11;
    logic signed [SW-1:0] w_zr, w_s0, w_s1;
    logic [QW-1:0]        w_base0, w_base1;
    logic [QW:0]          w_sum0, w_sum1, w_dif0, w_dif1;
    logic [QW-1:0]        w_res0, w_res1;

    always_comb begin
      w_r11   = mod_q(SW'(r1_p11));
      w_zr    = SW'(r1_z) * SW'($signed({1'b0, w_r11}));
      w_s0    = SW'(r1_p00) + w_zr;
      w_s1    = SW'(r1_p01) + SW'(r1_p10);
      w_base0 = w_fresh ? '0 : r_acc0;
      w_base1 = w_fresh ? '0 : r_acc1;
      w_sum0  = {1'b0, w_base0} + {1'b0, r3_t0};
      w_sum1  = {1'b0, w_base1} + {1'b0, r3_t1};
      w_dif0  = w_sum0 - QE;
      w_dif1  = w_sum1 - QE;
      w_res0  = (w_sum0 >= QE) ? w_dif0[QW-1:0] : w_sum0[QW-1:0];
      w_res1  = (w_sum1 >= QE) ? w_dif1[QW-1:0] : w_sum1[QW-1:0];
    end

    // Datapath registers need no reset: the valid chain qualifies them.
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r0_a1  <= $signed(a1[g*W +: W]);
        r0_a0  <= $signed(a0[g*W +: W]);
        r0_b1  <= $signed(b1[g*W +: W]);
        r0_b0  <= $signed(b0[g*W +: W]);
        r0_z   <= $signed(zeta[g*W +: W]);
        r1_p00 <= PW'(r0_a0) * PW'(r0_b0);
        r1_p11 <= PW'(r0_a1) * PW'(r0_b1);
        r1_p01 <= PW'(r0_a0) * PW'(r0_b1);
        r1_p10 <= PW'(r0_a1) * PW'(r0_b0);
        r1_z   <= r0_z;
        r2_s0  <= w_s0;
        r2_s1  <= w_s1;
        r3_t0  <= mod_q(r2_s0);
        r3_t1  <= mod_q(r2_s1);
      end
    end

    always_ff @(posedge clk) begin
      if (!set) begin
        r_acc0 <= '0;
        r_acc1 <= '0;
        r_t0   <= '0;
        r_t1   <= '0;
      end else if (w_adv && r3_v) begin
        if (r3_l) begin
          r_t0   <= w_res0;
          r_t1   <= w_res1;
          r_acc0 <= '0;
          r_acc1 <= '0;
        end else begin
          r_acc0 <= w_res0;
          r_acc1 <= w_res1;
        end
      end
    end

    assign t0[g*W +: W] = {{(W-QW){1'b0}}, r_t0};
    assign t1[g*W +: W] = {{(W-QW){1'b0}}, r_t1};
  end

endmodule

// File: tb/tb_basemul_acc.sv
// Directed bench for basemul_acc: a golden model fills an expected queue,
// a negedge monitor pops and compares every transferred result.
module tb_basemul_acc;
  localparam int LANES = 2;
  localparam int Q     = 3329;
  localparam int W     = 16;
  localparam int BW    = LANES * W;

  logic          clk = 1'b0;
  logic          set;
  logic          in_valid, in_ready, in_first, in_last;
  logic [BW-1:0] a1, a0, b1, b0, zeta;
  logic          out_valid, out_ready;
  logic [BW-1:0] t1, t0;
  logic          acc_err;

  always #5 clk = ~clk;

  basemul_acc #(.LANES(LANES), .Q(Q), .W(W)) dut (
    .clk(clk), .set(set), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .zeta(zeta),
    .out_valid(out_valid), .out_ready(out_ready),
    .t1(t1), .t0(t0), .acc_err(acc_err)
  );

  int            n_asserts = 0;
  int            n_fail    = 0;
  logic [2*BW-1:0] exp_q[$];
  longint        bacc0[LANES];
  longint        bacc1[LANES];
  logic          bp_en = 1'b0;
  int            bp_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [2*BW-1:0] prev_t = '0;

  task automatic chk(input string tag, input logic [2*BW-1:0] obs, input logic [2*BW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint md(input longint x);
    longint r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return r;
  endfunction

  // Reduce operands first, then form the degree-1 product mod (X^2 - zeta).
  function automatic void prod(input logic [W-1:0] xa1, xa0, xb1, xb0, xz,
                               output longint p0, output longint p1);
    longint sa1, sa0, sb1, sb0, sz;
    sa1 = md(longint'($signed(xa1)));
    sa0 = md(longint'($signed(xa0)));
    sb1 = md(longint'($signed(xb1)));
    sb0 = md(longint'($signed(xb0)));
    sz  = md(longint'($signed(xz)));
    p0  = md(sa0 * sb0 + sz * md(sa1 * sb1));
    p1  = md(sa0 * sb1 + sa1 * sb0);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LANES; i++) begin
      bacc0[i] = 0;
      bacc1[i] = 0;
    end
  endtask

  task automatic beat(input logic [BW-1:0] va1, va0, vb1, vb0, vz, input logic f, l);
    longint p0, p1;
    logic [BW-1:0] e0, e1;
    logic acc;
    int n;
    for (int i = 0; i < LANES; i++) begin
      prod(va1[i*W +: W], va0[i*W +: W], vb1[i*W +: W], vb0[i*W +: W], vz[i*W +: W], p0, p1);
      if (f) begin
        bacc0[i] = p0;
        bacc1[i] = p1;
      end else begin
        bacc0[i] = md(bacc0[i] + p0);
        bacc1[i] = md(bacc1[i] + p1);
      end
    end
    if (l) begin
      for (int i = 0; i < LANES; i++) begin
        e0[i*W +: W] = W'(bacc0[i]);
        e1[i*W +: W] = W'(bacc1[i]);
      end
      exp_q.push_back({e1, e0});
      clear_model();
    end
    a1 = va1; a0 = va0; b1 = vb1; b0 = vb0; zeta = vz;
    in_first = f; in_last = l; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", acc, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    set = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_t", {t1, t0}, 0);
    chk("rst_acc_err", acc_err, 0);
    set = 1'b1;
    clear_model();
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready = (bp_cyc % 3 == 0);
      bp_cyc++;
    end
  end

  always @(negedge clk) begin
    if (set) begin
      chk("in_ready_rule", in_ready, out_ready || !out_valid);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {t1, t0}, prev_t);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
        else chk("result", {t1, t0}, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_t     = {t1, t0};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic [BW-1:0] ra1, ra0, rb1, rb0, rz;
    set = 1'b0;
    idle();
    a1 = '0; a0 = '0; b1 = '0; b0 = '0; zeta = '0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_t", {t1, t0}, 0);
    chk("reset_acc_err", acc_err, 0);
    set = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // single term, both lanes, with latency check
    beat({16'd5, 16'd1}, {16'd6, 16'd2}, {16'd7, 16'd3}, {16'd8, 16'd4},
         {16'd321, 16'd789}, 1'b1, 1'b1);
    idle();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("latency_early", out_valid, 0);
    end
    @(posedge clk);
    #1;
    chk("latency_hit", out_valid, 1);
    chk("single_t0", t0, {16'd1296, 16'd2375});
    chk("single_t1", t1, {16'd82, 16'd10});
    wait_idle(50);

    // two-beat accumulation
    beat({16'd1, 16'd1}, {16'd2, 16'd2}, {16'd3, 16'd3}, {16'd4, 16'd4},
         {16'd789, 16'd789}, 1'b1, 1'b0);
    beat({16'd5, 16'd5}, {16'd6, 16'd6}, {16'd7, 16'd7}, {16'd8, 16'd8},
         {16'd321, 16'd321}, 1'b0, 1'b1);
    idle();
    wait_idle(50);
    chk("acc_t0", t0, {16'd342, 16'd342});
    chk("acc_t1", t1, {16'd92, 16'd92});
    chk("acc_no_err", acc_err, 0);

    // negative and extreme operands
    beat({16'd3328, 16'd0}, {16'd3328, 16'hFFFF}, {16'd3328, 16'd0}, {16'd3328, 16'd1},
         {16'd3328, 16'd5}, 1'b1, 1'b1);
    idle();
    wait_idle(50);
    chk("neg_t0", t0, {16'd0, 16'd3328});
    chk("neg_t1", t1, {16'd2, 16'd0});
    beat({16'h8000, 16'h8000}, {16'h8000, 16'h8000}, {16'h8000, 16'h8000},
         {16'h8000, 16'h8000}, {16'h8000, 16'h8000}, 1'b1, 1'b1);
    idle();
    wait_idle(50);

    // backpressure stream
    bp_cyc = 0;
    bp_en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ra1 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      ra0 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      rb1 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      rb0 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      rz  = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      beat(ra1, ra0, rb1, rb0, rz, 1'b1, 1'b1);
    end
    idle();
    wait_idle(300);
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    chk("bp_no_err", acc_err, 0);

    // protocol error: first, first, last
    beat({16'd9, 16'd9}, {16'd9, 16'd9}, {16'd9, 16'd9}, {16'd9, 16'd9},
         {16'd9, 16'd9}, 1'b1, 1'b0);
    beat({16'd1, 16'd11}, {16'd2, 16'd12}, {16'd3, 16'd13}, {16'd4, 16'd14},
         {16'd789, 16'd17}, 1'b1, 1'b0);
    beat({16'd5, 16'hFFF0}, {16'd6, 16'd20}, {16'd7, 16'd30}, {16'd8, 16'd40},
         {16'd321, 16'd50}, 1'b0, 1'b1);
    idle();
    wait_idle(50);
    chk("ffl_t0_lane1", t0[2*W-1:W], 16'd342);
    chk("err_first_open", acc_err, 1);
    beat({16'd1, 16'd1}, {16'd2, 16'd2}, {16'd3, 16'd3}, {16'd4, 16'd4},
         {16'd789, 16'd789}, 1'b1, 1'b1);
    idle();
    wait_idle(50);
    chk("err_sticky", acc_err, 1);

    // last without first from reset
    do_reset();
    beat({16'd1, 16'd5}, {16'd2, 16'd6}, {16'd3, 16'd7}, {16'd4, 16'd8},
         {16'd789, 16'd321}, 1'b0, 1'b1);
    idle();
    wait_idle(50);
    chk("lwf_t0", t0, {16'd2375, 16'd1296});
    chk("err_no_first", acc_err, 1);

    // reset mid-burst
    beat({16'd100, 16'd200}, {16'd300, 16'd400}, {16'd500, 16'd600}, {16'd700, 16'd800},
         {16'd17, 16'd1729}, 1'b1, 1'b0);
    idle();
    do_reset();
    beat({16'd5, 16'd1}, {16'd6, 16'd2}, {16'd7, 16'd3}, {16'd8, 16'd4},
         {16'd321, 16'd789}, 1'b1, 1'b1);
    idle();
    wait_idle(50);
    chk("fresh_t0", t0, {16'd1296, 16'd2375});
    chk("fresh_no_err", acc_err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("fresh_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/basemul_acc.md
# basemul_acc

Pipelined, multi-lane Kyber base-case multiplier with in-stream accumulation. Each lane computes the degree-1 product (a0 + a1·X)(b0 + b1·X) mod (X² − zeta) over Z_q and sums products across a burst of beats, which is the inner loop of the matrix-vector products Â·ŝ and ŝᵀ·û. It replaces single-pair `basemul` in the NTT-domain datapath and returns canonical coefficients with a valid/ready handshake.

## Interface
- `LANES`, default 2: number of independent coefficient-pair lanes.
- `Q`, default 3329: modulus; all outputs are in [0, Q).
- `W`, default 16: coefficient width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `set`  in  1: reset, synchronous, active-low; `set`=0 at a rising edge resets the block.
- `in_valid`  in  1: beat present on the input buses.
- `in_ready`  out  1: beat is accepted when `in_valid && in_ready`.
- `in_first`  in  1: beat starts a new accumulation.
- `in_last`  in  1: beat closes the accumulation; the result is emitted.
- `a1`, `a0`, `b1`, `b0`  in  LANES·W: per-lane signed coefficients. Lane i occupies bits [i·W +: W].
- `zeta`  in  LANES·W: per-lane signed twiddle.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: downstream accepts the result.
- `t1`, `t0`  out  LANES·W: per-lane results, unsigned canonical.
- `acc_err`  out  1: sticky protocol-error flag.

## Operation
- Per lane, with all inputs interpreted as signed W-bit values reduced exactly mod Q:
  - t0 = a0·b0 + zeta·((a1·b1) mod Q) mod Q
  - t1 = a0·b1 + a1·b0 mod Q
- The reduction method (Barrett, Montgomery with conversion, or subtract-chain) is free, but results must be exact and canonical for every 16-bit input combination.
- Accumulator, one per lane, holding the canonical (t1, t0) partial:
  - Beat with `in_first`: accumulator = product, discarding any partial.
  - Beat without `in_first`: accumulator = (accumulator + product) mod Q.
  - Beat with `in_last`: the final sum is loaded into the output register, and the accumulator is cleared to 0 with no burst open.
  - `in_first && in_last`: single-term result, equal to the product.
  - Non-last beats never produce output.
- Protocol errors set `acc_err`, which is cleared only by reset:
  - `in_first` while a burst is open. The partial is discarded and the new burst proceeds.
  - A beat without `in_first` while no burst is open. It accumulates onto the cleared accumulator (0), so the result is correct as if `in_first` had been set.
- All lanes share control and advance in lockstep.
- Reset values: `out_valid`=0, `t1`=`t0`=0, `acc_err`=0, all pipeline valids 0, accumulators 0, no burst open.
- Reset mid-burst discards every in-flight beat and the partial sum; nothing is emitted.

## Timing
- Pipeline has 4 register stages:
  - S1: input multiplies a0b0, a1b1, a0b1, a1b0.
  - S2: reduce a1b1, multiply by zeta, sum cross terms.
  - S3: final reduction to canonical.
  - S4: accumulate / output register.
- Latency: a last beat accepted at edge n gives `out_valid`=1 after edge n+4, provided there is no stall.
- Throughput: one beat per cycle per lane set.
- Stall is global: the pipeline advances iff `out_ready || !out_valid`.
- `in_ready` equals that condition, combinationally, so it is 1 out of reset.
- While stalled, all stages, `t1`/`t0` and `out_valid` hold stable.
- Output transfer happens at the edge where `out_valid && out_ready`. With `out_ready` held at 1, back-to-back single-term beats produce results on consecutive cycles.
- Simultaneous output transfer and new last beat reaching S4 in the same edge: the new result is loaded, with no bubble.

## Test plan
- Single term, lane 0: a1=1, a0=2, b1=3, b0=4, zeta=789, first=last=1 -> t0=2375, t1=10 after 4 cycles. Lane 1 in the same beat: 5, 6, 7, 8, zeta=321 -> t0=1296, t1=82.
- Accumulate two beats on one lane: (1,2,3,4,789) with first, then (5,6,7,8,321) with last -> exactly one output, t0=342, t1=92. No `out_valid` is seen for the first beat.
- Negative and extreme inputs:
  - a1=0, a0=−1, b1=0, b0=1 -> t0=3328, t1=0.
  - All inputs 3328, zeta 3328 -> t0=0, t1=2.
  - All inputs −32768, zeta −32768 -> compare against a golden model.
- Backpressure: stream 8 single-term beats with `out_ready` toggling 1,0,0,1,… -> `in_ready` tracks the stall rule, outputs are held stable while stalled, and all 8 results arrive in order with none lost or duplicated.
- Protocol errors:
  - first, first, last -> result equals the sum of the last two products, `acc_err`=1.
  - last without first, from reset -> equals the product.
  - `acc_err` stays 1 until `set`=0.
- Reset mid-burst: first beat, then `set`=0 for 1 cycle, then a fresh single-term beat -> only the fresh result is emitted, and `out_valid`=0, `t0`=`t1`=0 during reset.
